// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code set 2 key decoder.
// Pops bytes from the keyboard FIFO, tracks the held key and maps it to ASCII.
module ps2_key_decoder #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       kbd_data,
   input  logic             kbd_ready,
   input  logic             kbd_overflow,
   output logic             kbd_nextdata_n,
   output logic             key_valid,
   output logic [7:0]       key_code,
   output logic             key_ext,
   output logic [7:0]       key_ascii,
   output logic [CNT_W-1:0] key_count,
   output logic             press_pulse,
   output logic             release_pulse,
   output logic             err
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_POP,
      S_WAIT
   } state_t;

   state_t           state_q, state_d;
   logic [7:0]       byte_q, byte_d;
   logic             ext_pend_q, ext_pend_d;
   logic             brk_pend_q, brk_pend_d;
   logic             valid_q, valid_d;
   logic [7:0]       code_q, code_d;
   logic             ext_q, ext_d;
   logic [7:0]       ascii_q, ascii_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             press_q, press_d;
   logic             rel_q, rel_d;
   logic             err_q, err_d;
   logic             pop_n;
   logic             same_key;

   function automatic logic [7:0] map_code(input logic [7:0] b,
                                           input logic       ext);
      logic [7:0] a;
      a = 8'h00;
      if (!ext) begin
         unique case (b)
            8'h1C: a = 8'h61;
            8'h32: a = 8'h62;
            8'h21: a = 8'h63;
            8'h23: a = 8'h64;
            8'h24: a = 8'h65;
            8'h2B: a = 8'h66;
            8'h34: a = 8'h67;
            8'h33: a = 8'h68;
            8'h43: a = 8'h69;
            8'h3B: a = 8'h6A;
            8'h42: a = 8'h6B;
            8'h4B: a = 8'h6C;
            8'h3A: a = 8'h6D;
            8'h31: a = 8'h6E;
            8'h44: a = 8'h6F;
            8'h4D: a = 8'h70;
            8'h15: a = 8'h71;
            8'h2D: a = 8'h72;
            8'h1B: a = 8'h73;
            8'h2C: a = 8'h74;
            8'h3C: a = 8'h75;
            8'h2A: a = 8'h76;
            8'h1D: a = 8'h77;
            8'h22: a = 8'h78;
            8'h35: a = 8'h79;
            8'h1A: a = 8'h7A;
            8'h45: a = 8'h30;
            8'h16: a = 8'h31;
            8'h1E: a = 8'h32;
            8'h26: a = 8'h33;
            8'h25: a = 8'h34;
            8'h2E: a = 8'h35;
            8'h36: a = 8'h36;
            8'h3D: a = 8'h37;
            8'h3E: a = 8'h38;
            8'h46: a = 8'h39;
            8'h29: a = 8'h20;
            8'h5A: a = 8'h0D;
            default: a = 8'h00;
         endcase
      end
      return a;
   endfunction

   // Next-state: pop handshake, prefix tracking and make/break handling
   always_comb begin
      state_d    = state_q;
      byte_d     = byte_q;
      ext_pend_d = ext_pend_q;
      brk_pend_d = brk_pend_q;
      valid_d    = valid_q;
      code_d     = code_q;
      ext_d      = ext_q;
      ascii_d    = ascii_q;
      count_d    = count_q;
      press_d    = 1'b0;
      rel_d      = 1'b0;
      err_d      = err_q | kbd_overflow;
      pop_n      = 1'b1;
      same_key   = valid_q && (byte_q == code_q) &&
                   (ext_pend_q == ext_q);
      unique case (state_q)
         S_IDLE: begin
            if (kbd_ready) state_d = S_POP;
         end
         S_POP: begin
            pop_n   = 1'b0;
            byte_d  = kbd_data;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            state_d = S_IDLE;
            if (byte_q == 8'hE0) begin
               ext_pend_d = 1'b1;
            end else if (byte_q == 8'hF0) begin
               brk_pend_d = 1'b1;
            end else begin
               if (brk_pend_q) begin
                  if (same_key) begin
                     valid_d = 1'b0;
                     rel_d   = 1'b1;
                  end
               end else if (!same_key) begin
                  code_d  = byte_q;
                  ext_d   = ext_pend_q;
                  valid_d = 1'b1;
                  ascii_d = map_code(byte_q, ext_pend_q);
                  press_d = 1'b1;
                  count_d = count_q + CNT_W'(1);
               end
               ext_pend_d = 1'b0;
               brk_pend_d = 1'b0;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and output registers; reset discards any byte in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         byte_q     <= 8'h00;
         ext_pend_q <= 1'b0;
         brk_pend_q <= 1'b0;
         valid_q    <= 1'b0;
         code_q     <= 8'h00;
         ext_q      <= 1'b0;
         ascii_q    <= 8'h00;
         count_q    <= '0;
         press_q    <= 1'b0;
         rel_q      <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         byte_q     <= byte_d;
         ext_pend_q <= ext_pend_d;
         brk_pend_q <= brk_pend_d;
         valid_q    <= valid_d;
         code_q     <= code_d;
         ext_q      <= ext_d;
         ascii_q    <= ascii_d;
         count_q    <= count_d;
         press_q    <= press_d;
         rel_q      <= rel_d;
         err_q      <= err_d;
      end
   end

   assign kbd_nextdata_n = pop_n;
   assign key_valid      = valid_q;
   assign key_code       = code_q;
   assign key_ext        = ext_q;
   assign key_ascii      = ascii_q;
   assign key_count      = count_q;
   assign press_pulse    = press_q;
   assign release_pulse  = rel_q;
   assign err            = err_q;

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the press counter.
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port kbd_data  input  8  scan-code byte at the head of the ps2_keyboard FIFO.
REQ-005 SHALL have port kbd_ready  input  1  FIFO non-empty.
REQ-006 SHALL have port kbd_overflow  input  1  FIFO overflow flag.
REQ-007 SHALL have port kbd_nextdata_n  output  1  active-low pop strobe to ps2_keyboard.
REQ-008 SHALL have port key_valid  output  1  a key is currently held.
REQ-009 SHALL have port key_code  output  8  scan code of the most recent make.
REQ-010 SHALL have port key_ext  output  1  most recent make was E0-prefixed.
REQ-011 SHALL have port key_ascii  output  8  ASCII of key_code; 0x00 if unmapped.
REQ-012 SHALL have port key_count  output  CNT_W  count of new key presses.
REQ-013 SHALL have port press_pulse  output  1  one-cycle strobe on a new make.
REQ-014 SHALL have port release_pulse  output  1  one-cycle strobe on release of the held key.
REQ-015 SHALL have port err  output  1  sticky FIFO-overflow indicator.

Function
REQ-016 SHALL use a three-state FSM: IDLE, POP, WAIT.
REQ-017 IDLE -> POP when kbd_ready=1; otherwise stay in IDLE.
REQ-018 In POP: drive kbd_nextdata_n=0 for exactly that cycle, latch kbd_data, then go to WAIT.
REQ-019 In WAIT: drive kbd_nextdata_n=1, process the latched byte, then go to IDLE.
REQ-020 kbd_nextdata_n SHALL be low only in POP; pops are at least 3 cycles apart.
REQ-021 Byte 0xE0 SHALL set ext_pending; no outputs change.
REQ-022 Byte 0xF0 SHALL set brk_pending; no outputs change.
REQ-023 Any other byte b with brk_pending=1 is a break.
REQ-024 Break, when key_valid=1, b==key_code and ext_pending==key_ext:
- key_valid<=0
- release_pulse=1
REQ-025 A break not matching the held key SHALL change no outputs and raise no pulse.
REQ-026 Any other byte b with brk_pending=0 is a make.
REQ-027 Make, when key_valid=1, b==key_code and ext_pending==key_ext, is typematic repeat: no output changes, no pulse, no count.
REQ-028 Any other make SHALL set:
- key_code<=b, key_ext<=ext_pending, key_valid<=1
- key_ascii<=map(b, ext_pending)
- press_pulse=1
- key_count<=key_count+1, modulo 2^CNT_W (all-ones wraps to 0)
REQ-029 Processing a non-prefix byte SHALL clear both ext_pending and brk_pending.
REQ-030 map() SHALL use PS/2 scan-code set 2:
- letters -> lowercase a-z (0x1C->0x61, 0x1B->0x73)
- top-row digits (0x45->0x30, 0x16->0x31 ... 0x46->0x39)
- 0x29->0x20, 0x5A->0x0D
- ext=1 or any unmapped code -> 0x00
REQ-031 Latency: byte popped in cycle T (POP); outputs update at the end of T+1; pulses are high during T+2 only.
REQ-032 err SHALL set when kbd_overflow=1 is sampled and hold until reset.
REQ-033 A key-down SHALL always be reported, even when kbd_overflow and a pop occur in the same cycle.

Reset
REQ-034 On rst=1 at a clock edge, in any state:
- FSM -> IDLE, kbd_nextdata_n=1
- ext_pending=0, brk_pending=0
- key_valid=0, key_code=0, key_ext=0, key_ascii=0, key_count=0
- press_pulse=0, release_pulse=0, err=0
REQ-035 A byte in flight during reset SHALL be discarded; it is not re-popped.

Verification
REQ-036 Feed 0x1C, 0xF0, 0x1C -> press_pulse once with key_code=0x1C, key_ascii=0x61, key_count=1; then release_pulse once, key_valid=0.
REQ-037 Feed 0x1C x5, then 0xF0, 0x1C -> exactly one press_pulse, key_count=1, one release_pulse.
REQ-038 Feed 0xE0, 0x75, 0xE0, 0xF0, 0x75 -> key_ext=1, key_ascii=0x00, key_code=0x75; release only after the E0 F0 75 sequence.
REQ-039 Feed 0x1C, 0x1B, 0xF0, 0x1C -> key_code=0x1B, key_count=2; no release_pulse; key_valid stays 1.
REQ-040 kbd_ready held high with 256 distinct alternating makes (CNT_W=8) -> key_count wraps to 0; kbd_nextdata_n low exactly once per 3 cycles.
REQ-041 Assert rst during WAIT, and pulse kbd_overflow -> all outputs 0 after reset; err=1 after overflow and stays 1 until next reset.
